// File: rtl/scramble_multi_pkg.sv
// Shared constants, state type and LFSR helpers for the BLE whitening block.
package scramble_multi_pkg;

    localparam logic [6:0] BLE_WHITEN_POLY         = 7'b0010001;
    localparam logic       BLE_WHITEN_SEED_LSB     = 1'b1;
    localparam int         BLE_PREAMBLE_BITS       = 8;
    localparam int         BLE_ACCESS_ADDR_BITS    = 32;
    localparam int         BLE_BYPASS_BITS_DEFAULT = BLE_PREAMBLE_BITS + BLE_ACCESS_ADDR_BITS;
    localparam int         BLE_CHANNEL_BITS        = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } scramble_state_e;

    // Vector bit k holds LFSR position pk; the channel MSB lands in p1.
    function automatic logic [6:0] whiten_seed(input logic [5:0] ch);
        return {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], BLE_WHITEN_SEED_LSB};
    endfunction

    function automatic logic [6:0] whiten_step(input logic [6:0] p);
        return {p[5:0], 1'b0} ^ (p[6] ? BLE_WHITEN_POLY : 7'd0);
    endfunction

endpackage

// File: rtl/scramble_multi_whiten_lfsr.sv
// Whitening LFSR: optional seed load ahead of a DATA_WIDTH-step unroll,
// per-bit mask output, and reseed at frame end.
module whiten_lfsr
    import scramble_multi_pkg::*;
#(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seed_load,
    input  logic [5:0]            seed_chan,
    input  logic                  step,
    input  logic                  reload,
    output logic [DATA_WIDTH-1:0] mask
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;
    logic [6:0] start_state;
    logic [6:0] end_state;

    // A concurrent seed load feeds the unroll directly so that beat sees the new seed.
    always_comb begin
        start_state = seed_load ? whiten_seed(seed_chan) : lfsr_q;
        end_state   = start_state;
        mask        = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            mask[i]   = end_state[6];
            end_state = whiten_step(end_state);
        end
    end

    always_comb begin
        lfsr_d = start_state;
        if (reload) begin
            lfsr_d = whiten_seed(seed_chan);
        end else if (step) begin
            lfsr_d = end_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= whiten_seed(6'd0);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/scramble_multi.sv
// BLE data whitening/de-whitening with header bypass. Optional counter
// saturation and overrun flag are enabled by defining SCRAMBLE_OVERRUN_EN.
module scramble_multi
    import scramble_multi_pkg::*;
#(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int DATA_WIDTH               = 1,
    parameter int BYPASS_BITS              = BLE_BYPASS_BITS_DEFAULT,
    parameter int COUNT_WIDTH              = 12
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    input  logic                                channel_number_load,
    input  logic                                whiten_en,
    input  logic [DATA_WIDTH-1:0]               data_in,
    input  logic                                data_in_valid,
    input  logic                                data_in_valid_last,
    output logic [DATA_WIDTH-1:0]               data_out,
    output logic                                data_out_valid,
    output logic                                data_out_valid_last,
    output logic                                overrun
);

    localparam logic [COUNT_WIDTH:0] BYPASS_CNT  = (COUNT_WIDTH + 1)'(BYPASS_BITS);
    localparam logic [COUNT_WIDTH:0] STEP_CNT    = (COUNT_WIDTH + 1)'(DATA_WIDTH);
    localparam logic                 BYPASS_NONE = (BYPASS_BITS == 0);

    generate
        if ((BYPASS_BITS % DATA_WIDTH) != 0) begin : g_bad_bypass
            $error("BYPASS_BITS must be a multiple of DATA_WIDTH");
        end
    endgenerate

    logic [5:0] chan_in;
    generate
        if (CHANNEL_NUMBER_BIT_WIDTH >= BLE_CHANNEL_BITS) begin : g_chan_trunc
            assign chan_in = channel_number[5:0];
        end else begin : g_chan_ext
            assign chan_in = {{(BLE_CHANNEL_BITS - CHANNEL_NUMBER_BIT_WIDTH){1'b0}}, channel_number};
        end
    endgenerate

    scramble_state_e        state_q, state_d;
    logic [COUNT_WIDTH-1:0] bit_count_q, bit_count_d;
    logic [COUNT_WIDTH-1:0] count_adv;
    logic [5:0]             chan_q, chan_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [DATA_WIDTH-1:0]  mask;
    logic                   beat;
    logic                   frame_end;
    logic                   reach_payload;
    logic                   in_payload;
    logic                   whiten_beat;

    assign beat          = data_in_valid;
    assign frame_end     = data_in_valid & data_in_valid_last;
    assign reach_payload = ({1'b0, count_adv} >= BYPASS_CNT);
    assign whiten_beat   = beat & whiten_en & in_payload;

`ifdef SCRAMBLE_OVERRUN_EN
    logic [COUNT_WIDTH:0] count_sum;
    logic                 count_over;
    logic                 overrun_q, overrun_d;

    assign count_sum  = {1'b0, bit_count_q} + STEP_CNT;
    assign count_over = count_sum[COUNT_WIDTH];
    assign count_adv  = count_over ? '1 : count_sum[COUNT_WIDTH-1:0];

    // Sticky across the frame end; the next frame's first beat clears it.
    always_comb begin
        overrun_d = overrun_q;
        if (beat) begin
            overrun_d = ((state_q == IDLE) ? 1'b0 : overrun_q) | count_over;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    assign count_adv = bit_count_q + STEP_CNT[COUNT_WIDTH-1:0];
    assign overrun   = 1'b0;
`endif

    always_comb begin
        bit_count_d = bit_count_q;
        if (frame_end) begin
            bit_count_d = '0;
        end else if (beat) begin
            bit_count_d = count_adv;
        end
    end

    assign chan_d = channel_number_load ? chan_in : chan_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (beat) state_d = reach_payload ? PAYLOAD : HEADER;
            HEADER:  if (beat && reach_payload) state_d = PAYLOAD;
            // A wrapped counter drops back into header classification.
            PAYLOAD: if (beat && !reach_payload) state_d = HEADER;
            default: state_d = IDLE;
        endcase
        if (frame_end) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        in_payload = 1'b0;
        case (state_q)
            IDLE:    in_payload = BYPASS_NONE;
            HEADER:  in_payload = 1'b0;
            PAYLOAD: in_payload = 1'b1;
            default: in_payload = 1'b0;
        endcase
    end

    whiten_lfsr #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .seed_load (channel_number_load),
        .seed_chan (chan_d),
        .step      (whiten_beat),
        .reload    (frame_end),
        .mask      (mask)
    );

    assign data_out_d = data_in ^ (whiten_beat ? mask : '0);
    assign valid_d    = data_in_valid;
    assign last_d     = data_in_valid & data_in_valid_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_count_q <= '0;
            chan_q      <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_count_q <= bit_count_d;
            chan_q      <= chan_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
        end
    end

    assign data_out            = data_out_q;
    assign data_out_valid      = valid_q;
    assign data_out_valid_last = last_q;

endmodule

// File: tb/tb_scramble_multi.sv
// Self-checking bench for scramble_multi: DW=1, DW=8, a chained de-whitener
// and a narrow-counter instance, all checked against a bit-level reference.
module tb_scramble_multi;

    typedef bit   bitq_t[$];
    typedef logic logq_t[$];

`ifdef SCRAMBLE_OVERRUN_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] a_ch;
    logic       a_load, a_we, a_din, a_v, a_last;
    logic       a_dout, a_ov, a_olast, a_ovr;
    logic       r_dout, r_ov, r_olast, r_ovr;
    logic [5:0] b_ch;
    logic       b_load, b_we, b_v, b_last;
    logic [7:0] b_din, b_dout;
    logic       b_ov, b_olast, b_ovr;
    logic [5:0] c_ch;
    logic       c_load, c_we, c_din, c_v, c_last;
    logic       c_dout, c_ov, c_olast, c_ovr;

    scramble_multi #(.DATA_WIDTH(1)) u_a (
        .clk(clk), .rst(rst), .channel_number(a_ch), .channel_number_load(a_load),
        .whiten_en(a_we), .data_in(a_din), .data_in_valid(a_v), .data_in_valid_last(a_last),
        .data_out(a_dout), .data_out_valid(a_ov), .data_out_valid_last(a_olast), .overrun(a_ovr));

    scramble_multi #(.DATA_WIDTH(1)) u_r (
        .clk(clk), .rst(rst), .channel_number(a_ch), .channel_number_load(a_load),
        .whiten_en(1'b1), .data_in(a_dout), .data_in_valid(a_ov), .data_in_valid_last(a_olast),
        .data_out(r_dout), .data_out_valid(r_ov), .data_out_valid_last(r_olast), .overrun(r_ovr));

    scramble_multi #(.DATA_WIDTH(8)) u_b (
        .clk(clk), .rst(rst), .channel_number(b_ch), .channel_number_load(b_load),
        .whiten_en(b_we), .data_in(b_din), .data_in_valid(b_v), .data_in_valid_last(b_last),
        .data_out(b_dout), .data_out_valid(b_ov), .data_out_valid_last(b_olast), .overrun(b_ovr));

    scramble_multi #(.DATA_WIDTH(1), .COUNT_WIDTH(6)) u_c (
        .clk(clk), .rst(rst), .channel_number(c_ch), .channel_number_load(c_load),
        .whiten_en(c_we), .data_in(c_din), .data_in_valid(c_v), .data_in_valid_last(c_last),
        .data_out(c_dout), .data_out_valid(c_ov), .data_out_valid_last(c_olast), .overrun(c_ovr));

    // Whitening bit sequence for a channel, straight from the LFSR rules.
    function automatic bitq_t wseq(input int ch, input int n);
        bit    p[7];
        bit    w;
        bitq_t q;
        p[0] = 1'b1;
        for (int k = 1; k < 7; k++) p[k] = ch[6-k];
        for (int i = 0; i < n; i++) begin
            w = p[6];
            q.push_back(w);
            for (int k = 6; k > 0; k--) p[k] = p[k-1];
            p[0] = w;
            p[4] = p[4] ^ w;
        end
        return q;
    endfunction

    // Expected output bits of one frame: beats whose pre-count is below 40 pass,
    // others consume sequence bits when whiten_en is set for that beat.
    function automatic bitq_t model(input bitq_t din, input bitq_t we, input int ch,
                                    input int dw, input int cw, input bit sat);
        bitq_t seq;
        bitq_t dout;
        int    cnt;
        int    k;
        int    maxc;
        bit    wh;
        bit    x;
        seq  = wseq(ch, din.size());
        cnt  = 0;
        k    = 0;
        maxc = (1 << cw) - 1;
        for (int b = 0; b * dw < din.size(); b++) begin
            wh = we[b] && (cnt >= 40);
            for (int j = 0; j < dw; j++) begin
                x = din[b*dw+j];
                if (wh) begin
                    x = x ^ seq[k];
                    k++;
                end
                dout.push_back(x);
            end
            cnt = cnt + dw;
            if (cnt > maxc) cnt = sat ? maxc : cnt - (maxc + 1);
        end
        return dout;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        a_v = 0; a_last = 0; a_din = 0; a_load = 0; a_we = 1;
        b_v = 0; b_last = 0; b_din = 0; b_load = 0; b_we = 1;
        c_v = 0; c_last = 0; c_din = 0; c_load = 0; c_we = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_ch = 6'd37; a_load = 1; a_v = 1; a_din = 1; a_last = 1; a_we = 1;
        b_ch = 6'd37; b_load = 1; b_v = 1; b_din = 8'hff; b_last = 1; b_we = 1;
        c_ch = 6'd37; c_load = 1; c_v = 1; c_din = 1; c_last = 1; c_we = 1;
        tick();
        tick();
        n_tests++;
        if ({a_dout, a_ov, a_olast, a_ovr} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_a: got %b want 0000", {a_dout, a_ov, a_olast, a_ovr});
        end
        n_tests++;
        if ({r_dout, r_ov, r_olast, r_ovr} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_r: got %b want 0000", {r_dout, r_ov, r_olast, r_ovr});
        end
        n_tests++;
        if ({b_dout, b_ov, b_olast, b_ovr} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_b: got %b want 0", {b_dout, b_ov, b_olast, b_ovr});
        end
        n_tests++;
        if ({c_dout, c_ov, c_olast, c_ovr} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_c: got %b want 0000", {c_dout, c_ov, c_olast, c_ovr});
        end
        set_idle();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_dw1_ch37();
        bitq_t      din, we, exp;
        logq_t      got;
        logic [4:0] lead;
        lead = 5'b01101;
        a_ch = 6'd37; a_load = 1; tick(); a_load = 0;
        for (int i = 0; i < 48; i++) begin
            din.push_back(i < 40 ? bit'($urandom) : 1'b0);
            we.push_back(1'b1);
        end
        exp = model(din, we, 37, 1, 12, 1'b0);
        for (int i = 0; i < 48; i++) begin
            a_din = din[i]; a_v = 1; a_last = (i == 47);
            tick();
            got.push_back(a_dout);
            n_tests++;
            if (a_dout !== exp[i] || a_ov !== 1'b1 || a_olast !== (i == 47) || a_ovr !== 1'b0) begin
                n_fail++;
                $display("FAIL dw1_ch37 beat %0d: got d=%b v=%b last=%b ovr=%b want d=%b v=1 last=%b ovr=0",
                         i, a_dout, a_ov, a_olast, a_ovr, exp[i], i == 47);
            end
        end
        set_idle();
        tick();
        n_tests++;
        if (a_ov !== 1'b0 || a_olast !== 1'b0) begin
            n_fail++;
            $display("FAIL dw1_idle: got v=%b last=%b want 0 0", a_ov, a_olast);
        end
        for (int j = 0; j < 5; j++) begin
            n_tests++;
            if (got[40+j] !== lead[j]) begin
                n_fail++;
                $display("FAIL dw1_ch37_lead bit %0d: got %b want %b", j, got[40+j], lead[j]);
            end
        end
    endtask

    task automatic test_dw8_ch37();
        bitq_t      din, we, exp;
        logic [7:0] bytes [6];
        logic [7:0] want;
        logic [7:0] sixth;
        sixth = '0;
        b_ch = 6'd37; b_load = 1; tick(); b_load = 0;
        for (int b = 0; b < 6; b++) begin
            bytes[b] = (b < 5) ? 8'($urandom) : 8'h00;
            for (int j = 0; j < 8; j++) din.push_back(bytes[b][j]);
            we.push_back(1'b1);
        end
        exp = model(din, we, 37, 8, 12, 1'b0);
        for (int b = 0; b < 6; b++) begin
            b_din = bytes[b]; b_v = 1; b_last = (b == 5);
            tick();
            for (int j = 0; j < 8; j++) want[j] = exp[b*8+j];
            if (b == 5) sixth = b_dout;
            n_tests++;
            if (b_dout !== want || b_ov !== 1'b1 || b_olast !== (b == 5)) begin
                n_fail++;
                $display("FAIL dw8_beat %0d: got d=%h v=%b last=%b want d=%h v=1 last=%b",
                         b, b_dout, b_ov, b_olast, want, b == 5);
            end
        end
        set_idle();
        tick();
        n_tests++;
        if (sixth[4:0] !== 5'b01101 || b_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL dw8_lead: got bits=%b v=%b want bits=01101 v=0", sixth[4:0], b_ov);
        end
    endtask

    task automatic test_roundtrip();
        bitq_t din, we, exp;
        int    ch;
        int    n;
        n  = 240;
        ch = $urandom_range(0, 39);
        a_ch = 6'(ch); a_load = 1; tick(); a_load = 0;
        for (int i = 0; i < n; i++) begin
            din.push_back(bit'($urandom));
            we.push_back(1'b1);
        end
        exp = model(din, we, ch, 1, 12, 1'b0);
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                a_din = din[i]; a_v = 1; a_last = (i == n - 1);
            end else begin
                set_idle();
            end
            tick();
            if (i < n) begin
                n_tests++;
                if (a_dout !== exp[i] || a_ov !== 1'b1) begin
                    n_fail++;
                    $display("FAIL roundtrip_tx ch %0d beat %0d: got d=%b v=%b want d=%b v=1",
                             ch, i, a_dout, a_ov, exp[i]);
                end
            end
            if (i >= 1) begin
                n_tests++;
                if (r_dout !== din[i-1] || r_ov !== 1'b1 || r_olast !== (i == n)) begin
                    n_fail++;
                    $display("FAIL roundtrip_rx ch %0d beat %0d: got d=%b v=%b last=%b want d=%b v=1 last=%b",
                             ch, i - 1, r_dout, r_ov, r_olast, din[i-1], i == n);
                end
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bitq_t d1, d2, we, e1, e2;
        logq_t p1;
        int    ch;
        logic  want;
        ch = $urandom_range(0, 63);
        a_ch = 6'(ch); a_load = 1; tick(); a_load = 0;
        for (int i = 0; i < 64; i++) begin
            d1.push_back(i < 40 ? bit'($urandom) : 1'b0);
            d2.push_back(i < 40 ? bit'($urandom) : 1'b0);
            we.push_back(1'b1);
        end
        e1 = model(d1, we, ch, 1, 12, 1'b0);
        e2 = model(d2, we, ch, 1, 12, 1'b0);
        for (int i = 0; i < 128; i++) begin
            a_din = (i < 64) ? d1[i] : d2[i-64];
            a_v = 1; a_last = ((i % 64) == 63);
            want = (i < 64) ? e1[i] : e2[i-64];
            tick();
            if (i >= 40 && i < 64) p1.push_back(a_dout);
            n_tests++;
            if (a_dout !== want || a_olast !== ((i % 64) == 63)) begin
                n_fail++;
                $display("FAIL b2b beat %0d: got d=%b last=%b want d=%b last=%b",
                         i, a_dout, a_olast, want, (i % 64) == 63);
            end
            if (i >= 104) begin
                n_tests++;
                if (a_dout !== p1[i-104]) begin
                    n_fail++;
                    $display("FAIL b2b_repeat bit %0d: got %b want %b (first frame)", i - 104, a_dout, p1[i-104]);
                end
            end
        end
        set_idle();
        tick();
    endtask

    task automatic test_whiten_en_gaps();
        bitq_t din, we, exp;
        int    ch;
        int    beat;
        int    cyc;
        int    n;
        logic  raw;
        n  = 80;
        ch = $urandom_range(0, 63);
        a_ch = 6'(ch); a_load = 1; tick(); a_load = 0;
        for (int i = 0; i < n; i++) begin
            din.push_back(bit'($urandom));
            we.push_back(bit'($urandom));
        end
        exp  = model(din, we, ch, 1, 12, 1'b0);
        beat = 0;
        cyc  = 0;
        while (beat < n) begin
            cyc++;
            if (beat > 0 && cyc < 400 && $urandom_range(0, 3) == 0) begin
                raw = 1'($urandom);
                a_v = 0; a_din = raw; a_last = 1'($urandom); a_we = 1'($urandom);
                tick();
                n_tests++;
                if (a_dout !== raw || a_ov !== 1'b0 || a_olast !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gap cycle %0d: got d=%b v=%b last=%b want d=%b v=0 last=0",
                             cyc, a_dout, a_ov, a_olast, raw);
                end
            end else begin
                a_v = 1; a_din = din[beat]; a_we = we[beat]; a_last = (beat == n - 1);
                tick();
                n_tests++;
                if (a_dout !== exp[beat] || a_ov !== 1'b1 || a_olast !== (beat == n - 1)) begin
                    n_fail++;
                    $display("FAIL whiten_en beat %0d (we=%b): got d=%b v=%b last=%b want d=%b v=1 last=%b",
                             beat, we[beat], a_dout, a_ov, a_olast, exp[beat], beat == n - 1);
                end
                beat++;
            end
        end
        set_idle();
        tick();
    endtask

    task automatic test_load_midframe();
        bitq_t s1, s2, s3;
        int    c1, c2, c3;
        logic  want;
        c1 = $urandom_range(0, 63);
        c2 = (c1 + 1 + $urandom_range(0, 61)) % 64;
        c3 = (c2 + 1 + $urandom_range(0, 61)) % 64;
        s1 = wseq(c1, 5);
        s2 = wseq(c2, 6);
        s3 = wseq(c3, 9);
        a_ch = 6'(c1); a_load = 1; tick(); a_load = 0;
        for (int i = 0; i < 52; i++) begin
            a_din  = (i < 40) ? 1'($urandom) : 1'b0;
            a_v    = 1;
            a_last = (i == 51);
            a_load = (i == 45 || i == 51);
            a_ch   = (i >= 51) ? 6'(c3) : (i >= 45) ? 6'(c2) : 6'(c1);
            if (i < 40)      want = a_din;
            else if (i < 45) want = s1[i-40];
            else if (i < 51) want = s2[i-45];
            else             want = s3[0];
            tick();
            n_tests++;
            if (a_dout !== want) begin
                n_fail++;
                $display("FAIL load_mid beat %0d (ch %0d->%0d->%0d): got %b want %b", i, c1, c2, c3, a_dout, want);
            end
        end
        a_load = 0;
        for (int i = 0; i < 48; i++) begin
            a_din  = (i < 40) ? 1'($urandom) : 1'b0;
            a_v    = 1;
            a_last = (i == 47);
            want   = (i < 40) ? a_din : s3[i-40];
            tick();
            n_tests++;
            if (a_dout !== want) begin
                n_fail++;
                $display("FAIL load_at_end next-frame beat %0d (ch %0d): got %b want %b", i, c3, a_dout, want);
            end
        end
        set_idle();
        tick();
    endtask

    task automatic test_count_wrap();
        bitq_t din, we, exp, d2, w2, e2;
        int    ch;
        ch = $urandom_range(0, 63);
        c_ch = 6'(ch); c_load = 1; tick(); c_load = 0;
        for (int i = 0; i < 70; i++) begin
            din.push_back(bit'($urandom));
            we.push_back(1'b1);
        end
        for (int i = 0; i < 45; i++) begin
            d2.push_back(bit'($urandom));
            w2.push_back(1'b1);
        end
        exp = model(din, we, ch, 1, 6, OVR);
        e2  = model(d2, w2, ch, 1, 6, OVR);
        for (int i = 0; i < 70; i++) begin
            c_din = din[i]; c_v = 1; c_last = (i == 69);
            tick();
            n_tests++;
            if (c_dout !== exp[i] || c_ovr !== (OVR && i >= 63)) begin
                n_fail++;
                $display("FAIL count_wrap beat %0d: got d=%b ovr=%b want d=%b ovr=%b",
                         i, c_dout, c_ovr, exp[i], OVR && i >= 63);
            end
        end
        set_idle();
        tick();
        tick();
        n_tests++;
        if (c_ovr !== OVR) begin
            n_fail++;
            $display("FAIL overrun_sticky: got %b want %b", c_ovr, OVR);
        end
        for (int i = 0; i < 45; i++) begin
            c_din = d2[i]; c_v = 1; c_last = (i == 44);
            tick();
            n_tests++;
            if (c_dout !== e2[i] || c_ovr !== 1'b0) begin
                n_fail++;
                $display("FAIL count_next_frame beat %0d: got d=%b ovr=%b want d=%b ovr=0",
                         i, c_dout, c_ovr, e2[i]);
            end
        end
        set_idle();
        tick();
    endtask

    task automatic test_reset_midframe();
        bitq_t din, we, exp;
        a_ch = 6'($urandom_range(1, 63)); a_load = 1; tick(); a_load = 0;
        for (int i = 0; i < 50; i++) begin
            a_din = 1'($urandom); a_v = 1; a_last = 0;
            tick();
        end
        set_idle();
        rst = 1'b1;
        tick();
        n_tests++;
        if ({a_dout, a_ov, a_olast} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got %b want 000", {a_dout, a_ov, a_olast});
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 48; i++) begin
            din.push_back(bit'($urandom));
            we.push_back(1'b1);
        end
        exp = model(din, we, 0, 1, 12, 1'b0);
        for (int i = 0; i < 48; i++) begin
            a_din = din[i]; a_v = 1; a_last = (i == 47);
            tick();
            n_tests++;
            if (a_dout !== exp[i]) begin
                n_fail++;
                $display("FAIL reset_mid new-frame beat %0d (ch 0): got %b want %b", i, a_dout, exp[i]);
            end
        end
        set_idle();
        tick();
    endtask

    initial begin
        set_idle();
        a_ch = '0; b_ch = '0; c_ch = '0;
        test_reset();
        test_dw1_ch37();
        test_dw8_ch37();
        test_roundtrip();
        test_back_to_back();
        test_whiten_en_gaps();
        test_load_midframe();
        test_count_wrap();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
